div_reconstruct_seq: RTL and testbench

- Sequential inverse of the array divider: takes a divider result (quotient q, remainder r) plus the divisor d and rebuilds the dividend as n_hat = q*d + r.
- Uses shift-and-add, one quotient bit per clock.
- Compares n_hat against the original dividend n_ref and reports the absolute error and its direction.
- Sits behind the exact/approximate divider arrays in the error-characterisation path (power/MSE evaluation).

---
 rtl/div_reconstruct_seq.sv | 151 +++++++++++++++
 tb/tb_div_reconstruct_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_reconstruct_seq.sv
// rtl/div_reconstruct_seq.sv - rebuilds n_hat = q*d + r by shift-and-add and reports |n_ref - n_hat|
// Optional error statistics (sse, sample_cnt, stat_clr) are enabled by DIV_RECON_MSE_EN.
module div_reconstruct_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     q,
   input  logic [WIDTH-1:0]     d,
   input  logic [WIDTH-1:0]     r,
   input  logic [2*WIDTH-1:0]   n_ref,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   n_hat,
   output logic [2*WIDTH-1:0]   err,
   output logic                 err_neg,
   output logic                 busy
`ifdef DIV_RECON_MSE_EN
   ,
   input  logic                 stat_clr,
   output logic [4*WIDTH+7:0]   sse,
   output logic [15:0]          sample_cnt
`endif
);

   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     q_q, q_d, d_q, d_d, r_q, r_d;
   logic [2*WIDTH-1:0]   nref_q, nref_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [KW-1:0]        k_q, k_d;
   logic [2*WIDTH-1:0]   nhat_q, nhat_d, err_q, err_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   pp;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      nref_d  = nref_q;
      acc_d   = acc_q;
      k_d     = k_q;
      nhat_d  = nhat_q;
      err_d   = err_q;
      neg_d   = neg_q;
      pp      = q_q[k_q] ? ({{WIDTH{1'b0}}, d_q} << k_q) : '0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               q_d     = q;
               d_d     = d;
               r_d     = r;
               nref_d  = n_ref;
               acc_d   = '0;
               k_d     = '0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            acc_d = acc_q + pp;
            k_d   = k_q + 1'b1;
            if (k_q == KW'(WIDTH - 1)) state_d = S_ADD;
         end
         S_ADD: begin
            nhat_d  = acc_q + {{WIDTH{1'b0}}, r_q};
            err_d   = (nref_q >= nhat_d) ? (nref_q - nhat_d) : (nhat_d - nref_q);
            neg_d   = (nhat_d > nref_q);
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         nref_q  <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         nhat_q  <= '0;
         err_q   <= '0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         nref_q  <= nref_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         nhat_q  <= nhat_d;
         err_q   <= err_d;
         neg_q   <= neg_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign n_hat     = nhat_q;
   assign err       = err_q;
   assign err_neg   = neg_q;

`ifdef DIV_RECON_MSE_EN
   logic [4*WIDTH+7:0] sse_q, sse_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [4*WIDTH-1:0] err_sq;
   logic [4*WIDTH+8:0] sse_sum;

   // err_d is the error being produced this cycle; the clear takes priority over accumulation
   always_comb begin
      sse_d   = sse_q;
      cnt_d   = cnt_q;
      err_sq  = {{2*WIDTH{1'b0}}, err_d} * {{2*WIDTH{1'b0}}, err_d};
      sse_sum = {1'b0, sse_q} + {9'b0, err_sq};
      if (stat_clr) begin
         sse_d = '0;
         cnt_d = '0;
      end else if (state_q == S_ADD) begin
         sse_d = sse_sum[4*WIDTH+8] ? '1 : sse_sum[4*WIDTH+7:0];
         cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sse_q <= '0;
         cnt_q <= '0;
      end else begin
         sse_q <= sse_d;
         cnt_q <= cnt_d;
      end
   end

   assign sse        = sse_q;
   assign sample_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_div_reconstruct_seq.sv
// tb/tb_div_reconstruct_seq.sv - directed-vector bench for div_reconstruct_seq (DIV_RECON_MSE_EN optional)
module tb_div_reconstruct_seq;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [7:0]   q = '0, d = '0, r = '0;
   logic [15:0]  n_ref = '0;
   logic         in_ready, out_valid, err_neg, busy;
   logic [15:0]  n_hat, err;
`ifdef DIV_RECON_MSE_EN
   logic         stat_clr = 1'b0;
   logic [39:0]  sse;
   logic [15:0]  sample_cnt;
   bit           clr_in_add = 1'b0;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   div_reconstruct_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .q(q), .d(d), .r(r), .n_ref(n_ref),
      .out_valid(out_valid), .out_ready(out_ready),
      .n_hat(n_hat), .err(err), .err_neg(err_neg), .busy(busy)
`ifdef DIV_RECON_MSE_EN
      , .stat_clr(stat_clr), .sse(sse), .sample_cnt(sample_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_txn(input logic [7:0] tq, input logic [7:0] td, input logic [7:0] tr,
                         input logic [15:0] tn, input logic [15:0] en, input logic [15:0] ee,
                         input logic eneg, input int hold);
      int edges;
      bit seen;
      @(negedge clk);
      q = tq; d = td; r = tr; n_ref = tn;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      q = 8'hA5; d = 8'h5A; r = 8'h33; n_ref = 16'hBEEF;
      check("accept_busy", busy, 1);
      check("accept_in_ready", in_ready, 0);
      seen  = 1'b0;
      edges = 1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         edges++;
`ifdef DIV_RECON_MSE_EN
         stat_clr = clr_in_add && (edges == 9);
`endif
         if (out_valid) seen = 1'b1;
      end
      check("out_valid_timeout", seen, 1);
      check("latency_edges", edges, 10);
      check("n_hat", n_hat, en);
      check("err", err, ee);
      check("err_neg", err_neg, eneg);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         q = 8'h01; d = 8'h01; r = 8'h01; n_ref = 16'h0001;
         @(posedge clk); #1;
         check("hold_out_valid", out_valid, 1);
         check("hold_n_hat", n_hat, en);
         check("hold_err", err, ee);
         check("hold_in_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_out_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);
      check("release_busy", busy, 0);
      check("persist_n_hat", n_hat, en);
   endtask

   initial begin
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_n_hat", n_hat, 0);
      check("rst_err", err, 0);
      check("rst_err_neg", err_neg, 0);
`ifdef DIV_RECON_MSE_EN
      check("rst_sse", sse, 0);
      check("rst_cnt", sample_cnt, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      do_txn(8'h0C, 8'h0A, 8'h03, 16'h007B, 16'h007B, 16'h0000, 1'b0, 0);
      do_txn(8'hFF, 8'hFF, 8'hFF, 16'hFF00, 16'hFF00, 16'h0000, 1'b0, 0);
`ifdef DIV_RECON_MSE_EN
      check("mse_cnt_two_exact", sample_cnt, 2);
      check("mse_sse_two_exact", sse, 0);
      @(negedge clk); stat_clr = 1'b1;
      @(negedge clk); stat_clr = 1'b0;
      check("mse_clr_cnt", sample_cnt, 0);
      check("mse_clr_sse", sse, 0);
`endif
      do_txn(8'h10, 8'h0C, 8'h00, 16'h00C8, 16'h00C0, 16'h0008, 1'b0, 0);
      do_txn(8'h05, 8'h10, 8'h01, 16'h004E, 16'h0051, 16'h0003, 1'b1, 0);
`ifdef DIV_RECON_MSE_EN
      check("mse_sse_73", sse, 73);
      check("mse_cnt_2", sample_cnt, 2);
`endif
      do_txn(8'hFF, 8'h00, 8'h05, 16'h0005, 16'h0005, 16'h0000, 1'b0, 0);

      // 3*7+2 = 0x17 against 0x10: overshoot by 7, held in DONE for 5 cycles
`ifdef DIV_RECON_MSE_EN
      clr_in_add = 1'b1;
`endif
      do_txn(8'h03, 8'h07, 8'h02, 16'h0010, 16'h0017, 16'h0007, 1'b1, 5);
`ifdef DIV_RECON_MSE_EN
      clr_in_add = 1'b0;
      check("mse_add_clr_cnt", sample_cnt, 0);
      check("mse_add_clr_sse", sse, 0);
`endif

      @(negedge clk);
      q = 8'h0C; d = 8'h0A; r = 8'h03; n_ref = 16'h007B;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_n_hat", n_hat, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_err_neg", err_neg, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_txn(8'h0C, 8'h0A, 8'h03, 16'h007B, 16'h007B, 16'h0000, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
